mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one real fixed-point multiplier (signed Q1.(WIDTH-1) product, scaled by >>> (WIDTH-1)) among N_REQ requesters.
- Round-robin arbitration, valid/ready handshake on every requester port, two-stage registered pipeline, tagged response port with backpressure.
- Sits between the windowing/scaling engines and the single multiplier instance, so one DSP slice serves every real-valued scale operation.

Parameters:
- WIDTH, 16, operand and result width in bits (signed, Q1.(WIDTH-1)).
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index tag; must satisfy 2**ID_W >= N_REQ.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  N_REQ*WIDTH  flattened operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  flattened operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_id  out  ID_W  index of the requester that issued the result.
- rsp_data  out  WIDTH  scaled product.

Behaviour:
- Reset (async assert, sync release):
  - s1_valid, s2_valid, rsp_valid = 0.
  - rsp_id, rsp_data and operand/product registers = 0.
  - rr_ptr = 0.
  - req_ready = 0 while reset is high.
- Stall: stall = rsp_valid & ~rsp_ready. On stall, every pipeline register holds and req_ready = 0.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo N_REQ; the first set bit is the grant g.
  - req_ready[g] = ~stall; all other bits are 0.
  - No request means no grant and rr_ptr is unchanged.
- Accept: a handshake happens when req_valid[g] & req_ready[g]. On accept, rr_ptr <= (g+1) mod N_REQ.
- Stage 1 (accept edge): register a, b and g, set s1_valid. Without an accept and without a stall, s1_valid <= 0.
- Stage 2: product = signed(a)*signed(b) at 2*WIDTH bits, then arithmetic shift right by WIDTH-1, then keep the low WIDTH bits. This truncates toward minus infinity and wraps on overflow. Register the result with its id; s2_valid follows s1_valid.
- Output: rsp_valid, rsp_id and rsp_data are s2 registers, updated when not stalled.
- Latency: accept in cycle n gives rsp_valid in cycle n+2. Throughput is 1 per cycle with rsp_ready held high.
- Ordering: responses return in accept order. Data and id are held stable while rsp_valid & ~rsp_ready.
- Fairness: a requester holding req_valid is served within N_REQ accepts.
- Simultaneous events:
  - rsp_ready rising in a stalled cycle releases the stall that same cycle, so a new accept is allowed.
  - req_valid dropping without a handshake is legal and no grant is recorded.
- Reset mid-operation: in-flight operations are discarded and no response is produced for them.
- Only defined overflow case: (-1)*(-1). 0x8000*0x8000 gives 0x8000 by wrap.

Optional Feature:
- Macro: MULT_SHARE_SAT_EN.
- With the macro defined: stage 2 detects that the scaled product exceeds +(2**(WIDTH-1)-1) and outputs 0x7FFF (WIDTH=16) instead. Negative overflow cannot occur.
- Without the macro: wrap behaviour as above, with no extra logic.

Decomposition:
- Shared package/include (mult_share_pkg.vh) holds:
  - default WIDTH/N_REQ/ID_W;
  - the SHIFT = WIDTH-1 constant;
  - the MAX_POS constant (2**(WIDTH-1)-1).
- One natural sub-module: rr_arbiter (N_REQ, ID_W).
  - Inputs: req, ptr. Outputs: one-hot grant, grant index, any-grant.
  - Purely combinational; the top holds rr_ptr.
- The datapath multiply/scale stays inline in the top module.

Test Plan:
- Single requester 0: a=0x4000, b=0x4000, rsp_ready=1 -> two cycles later rsp_valid=1, rsp_id=0, rsp_data=0x2000.
- All four requesters valid every cycle with distinct operands, rsp_ready=1 -> grants issue in order 0,1,2,3,0,...; responses return in that order with correct products, one per cycle.
- rsp_ready=0 for 5 cycles with the pipe full -> rsp_data/rsp_id stable, req_ready=0 throughout, no loss or duplication after release.
- a=0xC000 (-0.5), b=0x6000 (0.75) -> rsp_data=0xD000; a=0xFFFF, b=0x0001 -> 0xFFFF (truncation toward -inf).
- a=b=0x8000 -> 0x8000 without MULT_SHARE_SAT_EN, 0x7FFF with it.
- Assert reset with two operations in flight -> rsp_valid drops immediately, no responses after release, and the first grant goes to requester 0.

Source files
------------

// File: rtl/mult_share_arbiter_pkg.sv
// Shared defaults and scaling constants for the multiplier-sharing arbiter.
package mult_share_arbiter_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_ID_W  = 2;

  // Right shift that rescales a Q1.(W-1) x Q1.(W-1) product back to Q1.(W-1).
  function automatic int shift_of(input int width);
    return width - 32'sd1;
  endfunction

  function automatic int max_pos_of(input int width);
    return (32'sd1 <<< (width - 32'sd1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping.
module mult_share_arbiter_rr_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_idx_o,
  output logic             any_grant_o
);

  int idx_s;

  // Priority scan rotated by the pointer; first hit wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    idx_s       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = int'(ptr_i) + k;
      if (idx_s >= N_REQ) begin
        idx_s = idx_s - N_REQ;
      end else begin
        idx_s = idx_s;
      end
      if (!any_grant_o && (|(req_i & (N_REQ'(1'b1) << idx_s)))) begin
        any_grant_o = 1'b1;
        grant_o     = N_REQ'(1'b1) << idx_s;
        grant_idx_o = ID_W'(idx_s);
      end else begin
        any_grant_o = any_grant_o;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin front end sharing one signed Q1.(WIDTH-1) multiplier over a 2-stage pipe.
// Define MULT_SHARE_SAT_EN to clamp the single positive overflow case instead of wrapping.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data
);

  localparam int SHIFT = shift_of(WIDTH);

  logic [N_REQ-1:0] grant_oh_s;
  logic [ID_W-1:0]  grant_idx_s;
  logic             any_grant_s;
  logic             stall_s;
  logic             accept_s;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;

  logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic             s1_valid_q,  s1_valid_d;
  logic [WIDTH-1:0] s1_a_q,      s1_a_d;
  logic [WIDTH-1:0] s1_b_q,      s1_b_d;
  logic [ID_W-1:0]  s1_id_q,     s1_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;

  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [2*WIDTH-1:0] scaled_s;
  logic [WIDTH-1:0]          result_s;
  logic                      prod_unused_s;

  mult_share_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant_oh_s),
    .grant_idx_o (grant_idx_s),
    .any_grant_o (any_grant_s)
  );

  assign stall_s   = rsp_valid_q & ~rsp_ready;
  assign accept_s  = any_grant_s & ~stall_s;
  assign req_ready = reset ? '0 : (grant_oh_s & {N_REQ{~stall_s}});

  // One-hot AND-OR mux picks the granted requester's operands.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      a_sel_s = a_sel_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{grant_oh_s[i]}});
      b_sel_s = b_sel_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{grant_oh_s[i]}});
    end
  end

  assign prod_s   = (2*WIDTH)'($signed(s1_a_q)) * (2*WIDTH)'($signed(s1_b_q));
  assign scaled_s = prod_s >>> SHIFT;
  assign prod_unused_s = ^prod_s;

`ifdef MULT_SHARE_SAT_EN
  localparam logic signed [2*WIDTH-1:0] MAX_POS_W = (2*WIDTH)'(max_pos_of(WIDTH));

  // Only (-1)*(-1) can exceed the positive range; clamp it.
  always_comb begin
    if (scaled_s > MAX_POS_W) begin
      result_s = MAX_POS_W[WIDTH-1:0];
    end else begin
      result_s = scaled_s[WIDTH-1:0];
    end
  end
`else
  assign result_s = scaled_s[WIDTH-1:0];
`endif

  // Next-state: everything holds under stall, otherwise the pipe advances one stage.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (stall_s) begin
      s1_valid_d = s1_valid_q;
    end else begin
      s1_valid_d  = accept_s;
      rsp_valid_d = s1_valid_q;
      if (accept_s) begin
        s1_a_d  = a_sel_s;
        s1_b_d  = b_sel_s;
        s1_id_d = grant_idx_s;
        if (grant_idx_s == ID_W'(N_REQ - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_idx_s + ID_W'(1'b1);
        end
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
      if (s1_valid_q) begin
        rsp_id_d   = s1_id_q;
        rsp_data_d = result_s;
      end else begin
        rsp_id_d   = rsp_id_q;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed and randomized bench for mult_share_arbiter against a queue-based reference model.
// Compile with +define+MULT_SHARE_SAT_EN to check the saturating build.
module tb_mult_share_arbiter;

  localparam int WIDTH = 16;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

`ifdef MULT_SHARE_SAT_EN
  localparam logic [15:0] EXP_MIN_SQ = 16'h7FFF;
`else
  localparam logic [15:0] EXP_MIN_SQ = 16'h8000;
`endif

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_data;

  logic [WIDTH-1:0] op_a [N_REQ];
  logic [WIDTH-1:0] op_b [N_REQ];

  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          age;
  } op_t;

  op_t q[$];
  int  m_ptr;
  int  m_g;
  bit  m_stall;
  bit  m_found;
  bit  m_vis;

  always #5 clock = ~clock;

  mult_share_arbiter #(
    .WIDTH (WIDTH),
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  // Real-number-style reference: full product, floor divide by 2^15, keep 16 bits.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint s;
    p = longint'($signed(a)) * longint'($signed(b));
    s = p >>> 15;
`ifdef MULT_SHARE_SAT_EN
    if (s > 64'sd32767) s = 64'sd32767;
`endif
    return s[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare DUT outputs against the model at the falling edge.
  task automatic sample();
    logic [1:0] idx;
    logic [3:0] exp_rdy;
    @(negedge clock);
    m_vis   = (q.size() > 0) && (q[0].age == 2);
    m_stall = m_vis && !rsp_ready;
    m_found = 1'b0;
    m_g     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = 2'(m_ptr + k);
      if (!m_found && req_valid[idx]) begin
        m_found = 1'b1;
        m_g     = int'(idx);
      end
    end
    exp_rdy = (m_found && !m_stall) ? 4'(4'b0001 << m_g) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_vis));
    if (m_vis) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
    end
  endtask

  // Advance the model across the rising edge.
  task automatic advance();
    op_t n;
    @(posedge clock);
    if (!m_stall) begin
      if (m_vis) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (m_found) begin
        n.id   = m_g;
        n.data = ref_mul(op_a[m_g], op_b[m_g]);
        n.age  = 1;
        q.push_back(n);
        m_ptr  = (m_g + 1) % N_REQ;
      end
    end
    #1;
  endtask

  task automatic op_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp);
    op_a[0]   = a;
    op_b[0]   = b;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    sample(); advance();
    req_valid = 4'b0000;
    sample(); advance();
    sample();
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'd0);
    chk(tag, 32'(rsp_data), 32'(exp));
    advance();
  endtask

  task automatic all_valid_distinct();
    req_valid = 4'b1111;
    for (int i = 0; i < N_REQ; i++) begin
      op_a[i] = 16'(16'h1000 * (i + 1));
      op_b[i] = 16'(16'hF000 + 16'h0123 * i);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      op_a[i] = 16'h0000;
      op_b[i] = 16'h0000;
    end
    m_ptr = 0;
    q.delete();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    req_valid = 4'b0000;
    reset     = 1'b0;

    op_single("half_sq", 16'h4000, 16'h4000, 16'h2000);
    op_single("neg_mix", 16'hC000, 16'h6000, 16'hD000);
    op_single("trunc", 16'hFFFF, 16'h0001, 16'hFFFF);
    op_single("min_sq", 16'h8000, 16'h8000, EXP_MIN_SQ);

    // Fill the pipe, stall it for five cycles, then release.
    all_valid_distinct();
    rsp_ready = 1'b1;
    repeat (3) begin sample(); advance(); end
    rsp_ready = 1'b0;
    repeat (5) begin sample(); advance(); end
    rsp_ready = 1'b1;
    repeat (4) begin sample(); advance(); end
    req_valid = 4'b0000;
    repeat (3) begin sample(); advance(); end

    // Reset with two operations in flight.
    all_valid_distinct();
    repeat (2) begin sample(); advance(); end
    reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    q.delete();
    m_ptr = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("rr_order", 32'(req_ready), 32'(4'(4'b0001 << (i % 4))));
      advance();
    end

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N_REQ; i++) begin
        op_a[i] = 16'($urandom);
        op_b[i] = 16'($urandom);
      end
      if ((c % 37) == 0) begin
        op_a[c % 4] = 16'h8000;
        op_b[c % 4] = 16'h8000;
      end
      sample(); advance();
    end

    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    repeat (4) begin sample(); advance(); end
    #1;
    chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
